// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: default widths,
// the NOP control value and the bit layout of the WB/M/EX control bundle.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // Control bundle layout: {WB[1:0], M[1:0], EX[3:0]}
  localparam int CTRL_EX_LSB = 0;
  localparam int CTRL_EX_W   = 4;
  localparam int CTRL_M_LSB  = 4;
  localparam int CTRL_M_W    = 2;
  localparam int CTRL_WB_LSB = 6;
  localparam int CTRL_WB_W   = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; increments once per cycle with inc_i and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register: main register M feeds the outputs, skid
// register S absorbs one entry under back-pressure; supports stall and flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              m_vld_q, m_vld_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_vld_q, s_vld_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              acc;
  logic              rel;

  // Ready depends on S only; stall/flush gate it combinationally.
  assign in_ready_o = ~s_vld_q & ~stall_i & ~flush_i & ~rst_i;
  assign acc        = in_valid_i & in_ready_o;
  assign rel        = m_vld_q & out_ready_i & ~stall_i & ~flush_i;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_vld_d  = s_vld_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!stall_i) begin
      if (rel && s_vld_q) begin
        m_vld_d  = 1'b1;
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        s_vld_d  = 1'b0;
      end else if (rel || !m_vld_q) begin
        m_vld_d = acc;
        if (acc) begin
          m_ctrl_d = in_ctrl_i;
          m_data_d = in_data_i;
        end
      end else if (acc) begin
        s_vld_d  = 1'b1;
        s_ctrl_d = in_ctrl_i;
        s_data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_vld_q  <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_vld_q  <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_vld_q  <= s_vld_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

  assign out_valid_o = m_vld_q;
  assign out_ctrl_o  = m_vld_q ? m_ctrl_q : '0;
  assign out_data_o  = m_data_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_ready_i & ~m_vld_q & ~stall_i),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, back-pressure, flush,
// stall and counter saturation (second instance with 4-bit counters).
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [31:0] s_out_data;
  logic [3:0]  s_stall_cnt;
  logic [3:0]  s_bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl),
    .out_data_o(out_data), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_ctrl_o(s_out_ctrl),
    .out_data_o(s_out_data), .stall_cnt_o(s_stall_cnt), .bubble_cnt_o(s_bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_ctrl = 8'h00; in_data = 32'h0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL reset_out_ctrl got %h want 00", out_ctrl); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin n_err++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = 32'h10; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h10 || out_ctrl !== 8'h05) begin n_err++; $display("FAIL stream_0 got v=%b d=%h c=%h want 1/10/05", out_valid, out_data, out_ctrl); end
    in_data = 32'h11;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin n_err++; $display("FAIL stream_1 got v=%b d=%h want 1/11", out_valid, out_data); end
    in_data = 32'h12;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h12) begin n_err++; $display("FAIL stream_2 got v=%b d=%h want 1/12", out_valid, out_data); end
    n_cmp++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL stream_bubble got %0d want 1", bubble_cnt); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_err++; $display("FAIL stream_drain got v=%b c=%h want 0/00", out_valid, out_ctrl); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = 32'hA0; out_ready = 1'b0;
    step();
    in_data = 32'hA1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin n_err++; $display("FAIL bp_hold_a0 got v=%b d=%h want 1/a0", out_valid, out_data); end
    in_data = 32'hA2;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low got %b want 0", in_ready); end
    step();
    n_cmp++; if (out_data !== 32'hA0) begin n_err++; $display("FAIL bp_stable got %h want a0", out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin n_err++; $display("FAIL bp_a1 got v=%b d=%h want 1/a1", out_valid, out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_a2 got v=%b d=%h want v=0", out_valid, out_data); end
    out_ready = 1'b0;
    n_cmp++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL bp_bubble got %0d want 1", bubble_cnt); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = 32'hB0; out_ready = 1'b0;
    step();
    in_data = 32'hB1;
    step();
    in_data = 32'hB2; flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_err++; $display("FAIL flush_out got v=%b c=%h want 0/00", out_valid, out_ctrl); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_entry got v=%b d=%h want v=0", out_valid, out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_back got %b want 1", in_ready); end
    out_ready = 1'b0;
    n_cmp++; if (bubble_cnt !== 16'd2) begin n_err++; $display("FAIL flush_bubble got %0d want 2", bubble_cnt); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = 32'hC0; out_ready = 1'b0;
    step();
    stall = 1'b1; out_ready = 1'b1; in_data = 32'hC1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hC0) begin n_err++; $display("FAIL stall_frozen_%0d got v=%b d=%h want 1/c0", i, out_valid, out_data); end
    end
    stall = 1'b0; in_valid = 1'b0;
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 16'd2) begin n_err++; $display("FAIL stall_bubble got %0d want 2", bubble_cnt); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got v=%b d=%h want v=0", out_valid, out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = 32'hD0; out_ready = 1'b0;
    step();
    in_data = 32'hD1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got v=%b r=%b want 1/0", out_valid, in_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_err++; $display("FAIL mid_async_out got v=%b c=%h want 0/00", out_valid, out_ctrl); end
    n_cmp++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin n_err++; $display("FAIL mid_async_cnt got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
    step();
    rst = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_skid_cleared_0 got v=%b d=%h want v=0", out_valid, out_data); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_skid_cleared_1 got v=%b d=%h want v=0", out_valid, out_data); end
    n_cmp++; if (bubble_cnt !== 16'd2 || s_bubble_cnt !== 4'd2) begin n_err++; $display("FAIL mid_bubble got %0d/%0d want 2/2", bubble_cnt, s_bubble_cnt); end
  endtask

  task automatic test_saturation();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (s_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_stall_20 got %0d want 15", s_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd20) begin n_err++; $display("FAIL wide_stall_20 got %0d want 20", stall_cnt); end
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (s_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_stall_25 got %0d want 15", s_stall_cnt); end
    n_cmp++; if (stall_cnt !== 16'd25) begin n_err++; $display("FAIL wide_stall_25 got %0d want 25", stall_cnt); end
    n_cmp++; if (s_bubble_cnt !== 4'd2) begin n_err++; $display("FAIL sat_bubble got %0d want 2", s_bubble_cnt); end
    stall = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_stall();
    test_reset_midstream();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
